// File: rtl/cordic_pkg.sv
// cordic_pkg: mode encodings, high-precision angle/gain constants and the
// rounding helper shared by the CORDIC engine and its stages.
package cordic_pkg;

    typedef enum logic {CORDIC_ROT = 1'b0, CORDIC_VEC = 1'b1} cordic_mode_e;

    // pi in Q3.45 and the CORDIC gain prescale 0.6072529350 in Q2.46
    localparam logic [47:0] PI_Q45 = 48'h6487_ED51_10B4;
    localparam logic [47:0] K_Q46  = 48'h26DD_3B6A_10D5;

    // atan(2^-i) in Q3.45 from its odd power series, summed with 16 guard bits
    function automatic logic [47:0] atan_q45(input int i);
        longint acc = 0;
        longint t;
        if (i == 0)
            return PI_Q45 >> 2;
        for (int k = 0; k < 31; k++) begin
            if ((2 * k + 1) * i <= 61) begin
                t = (64'sd1 <<< (61 - (2 * k + 1) * i)) / longint'(2 * k + 1);
                acc += (k % 2 != 0) ? -t : t;
            end
        end
        return 48'((acc + 64'sd32768) >>> 16);
    endfunction

    localparam logic [47:0] ATAN_TAB [0:31] = '{
        atan_q45(0),  atan_q45(1),  atan_q45(2),  atan_q45(3),
        atan_q45(4),  atan_q45(5),  atan_q45(6),  atan_q45(7),
        atan_q45(8),  atan_q45(9),  atan_q45(10), atan_q45(11),
        atan_q45(12), atan_q45(13), atan_q45(14), atan_q45(15),
        atan_q45(16), atan_q45(17), atan_q45(18), atan_q45(19),
        atan_q45(20), atan_q45(21), atan_q45(22), atan_q45(23),
        atan_q45(24), atan_q45(25), atan_q45(26), atan_q45(27),
        atan_q45(28), atan_q45(29), atan_q45(30), atan_q45(31)
    };

    // Round a 48-bit constant down to a w-bit word; the caller keeps the low w bits
    function automatic logic [47:0] q_round(input logic [47:0] v, input int w);
        return (v + (48'd1 << (47 - w))) >> (48 - w);
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// cordic_stage: one registered micro-rotation by atan(2^-IDX), direction chosen
// from z (rotation) or y (vectoring); mode and valid travel with the sample.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int W = 21,
    parameter int IDX = 0,
    parameter logic signed [W-1:0] ANGLE = '0
) (
    input  logic                clock,
    input  logic                aclr_n,
    input  logic                clk_en,
    input  logic signed [W-1:0] x_i,
    input  logic signed [W-1:0] y_i,
    input  logic signed [W-1:0] z_i,
    input  logic                mode_i,
    input  logic                valid_i,
    output logic signed [W-1:0] x_o,
    output logic signed [W-1:0] y_o,
    output logic signed [W-1:0] z_o,
    output logic                mode_o,
    output logic                valid_o
);
    logic                neg;
    logic signed [W-1:0] x_d, y_d, z_d, x_q, y_q, z_q;
    logic                mode_d, valid_d, mode_q, valid_q;

    // neg selects d = -1
    always_comb begin
        neg     = (mode_i == CORDIC_VEC) ? ~y_i[W-1] : z_i[W-1];
        x_d     = neg ? x_i + (y_i >>> IDX) : x_i - (y_i >>> IDX);
        y_d     = neg ? y_i - (x_i >>> IDX) : y_i + (x_i >>> IDX);
        z_d     = neg ? z_i + ANGLE : z_i - ANGLE;
        mode_d  = mode_i;
        valid_d = valid_i;
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (clk_en) begin
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
        end
    end

    assign x_o     = x_q;
    assign y_o     = y_q;
    assign z_o     = z_q;
    assign mode_o  = mode_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/cordic_engine_param.sv
// cordic_engine_param: fully pipelined CORDIC, per-sample rotation (cos/sin) or
// vectoring (magnitude/atan2), full-circle via pre-rotation, clk_en stall.
module cordic_engine_param
    import cordic_pkg::*;
#(
    parameter int W = 21,
    parameter int STAGES = 16
) (
    input  logic                clock,
    input  logic                aclr_n,
    input  logic                clk_en,
    input  logic                in_valid,
    input  logic                in_mode,
    input  logic signed [W-1:0] in_x,
    input  logic signed [W-1:0] in_y,
    input  logic signed [W-1:0] in_z,
    output logic                out_valid,
    output logic                out_mode,
    output logic signed [W-1:0] out_x,
    output logic signed [W-1:0] out_y,
    output logic signed [W-1:0] out_z
);
    localparam logic signed [W-1:0] PI_Q  = W'(q_round(PI_Q45, W));
    localparam logic signed [W-1:0] HPI_Q = W'(q_round(PI_Q45 >> 1, W));
    localparam logic signed [W-1:0] KQ    = W'(q_round(K_Q46, W));

    logic                vec, hi, lo, flip;
    logic signed [W-1:0] pre_x_d, pre_y_d, pre_z_d, pre_x_q, pre_y_q, pre_z_q;
    logic                pre_mode_d, pre_valid_d, pre_mode_q, pre_valid_q;
    logic signed [W-1:0] out_x_d, out_y_d, out_z_d, out_x_q, out_y_q, out_z_q;
    logic                out_mode_d, out_valid_d, out_mode_q, out_valid_q;
    logic signed [W-1:0] sx [0:STAGES];
    logic signed [W-1:0] sy [0:STAGES];
    logic signed [W-1:0] sz [0:STAGES];
    logic                sm [0:STAGES];
    logic                sv [0:STAGES];

    // Fold |angle| > pi/2 (or x < 0) into the right half-plane the stages converge over
    always_comb begin
        vec         = (in_mode == CORDIC_VEC);
        hi          = in_z > HPI_Q;
        lo          = in_z < -HPI_Q;
        flip        = in_x[W-1];
        pre_x_d     = vec ? (flip ? -in_x : in_x) : ((hi || lo) ? -KQ : KQ);
        pre_y_d     = vec ? (flip ? -in_y : in_y) : '0;
        pre_z_d     = vec ? (flip ? (in_y[W-1] ? -PI_Q : PI_Q) : '0)
                          : (hi ? in_z - PI_Q : lo ? in_z + PI_Q : in_z);
        pre_mode_d  = in_mode;
        pre_valid_d = in_valid;
        out_x_d     = sx[STAGES];
        out_y_d     = sy[STAGES];
        out_z_d     = sz[STAGES];
        out_mode_d  = sm[STAGES];
        out_valid_d = sv[STAGES];
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            pre_x_q     <= '0;
            pre_y_q     <= '0;
            pre_z_q     <= '0;
            pre_mode_q  <= 1'b0;
            pre_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_z_q     <= '0;
            out_mode_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (clk_en) begin
            pre_x_q     <= pre_x_d;
            pre_y_q     <= pre_y_d;
            pre_z_q     <= pre_z_d;
            pre_mode_q  <= pre_mode_d;
            pre_valid_q <= pre_valid_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_z_q     <= out_z_d;
            out_mode_q  <= out_mode_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sx[0] = pre_x_q;
    assign sy[0] = pre_y_q;
    assign sz[0] = pre_z_q;
    assign sm[0] = pre_mode_q;
    assign sv[0] = pre_valid_q;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        cordic_stage #(
            .W     (W),
            .IDX   (g),
            .ANGLE (W'(q_round(ATAN_TAB[g], W)))
        ) u_stage (
            .clock   (clock),
            .aclr_n  (aclr_n),
            .clk_en  (clk_en),
            .x_i     (sx[g]),
            .y_i     (sy[g]),
            .z_i     (sz[g]),
            .mode_i  (sm[g]),
            .valid_i (sv[g]),
            .x_o     (sx[g+1]),
            .y_o     (sy[g+1]),
            .z_o     (sz[g+1]),
            .mode_o  (sm[g+1]),
            .valid_o (sv[g+1])
        );
    end

    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_z     = out_z_q;
    assign out_mode  = out_mode_q;
    assign out_valid = out_valid_q;
endmodule
